// File: rtl/core_cache_arb.sv
// core_cache_arb: round-robin arbiter from NUM_CORES request ports onto one
// cache port. The winning request is registered toward the cache, and an
// owner-ID FIFO routes in-order cache responses back to the issuing core.
module core_cache_arb #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CORES-1:0]          core_req_valid,
  output logic [NUM_CORES-1:0]          core_req_ready,
  input  logic [NUM_CORES-1:0]          core_req_we,
  input  logic [NUM_CORES*ADDR_W-1:0]   core_req_addr,
  input  logic [NUM_CORES*DATA_W-1:0]   core_req_wdata,
  output logic [NUM_CORES-1:0]          core_rsp_valid,
  output logic [DATA_W-1:0]             core_rsp_rdata,
  output logic                          cache_req_valid,
  input  logic                          cache_req_ready,
  output logic                          cache_req_we,
  output logic [ADDR_W-1:0]             cache_req_addr,
  output logic [DATA_W-1:0]             cache_req_wdata,
  input  logic                          cache_rsp_valid,
  input  logic [DATA_W-1:0]             cache_rsp_rdata,
  output logic                          err_unsolicited
);

  localparam int ID_W  = $clog2(NUM_CORES);
  localparam int PTR_W = $clog2(MAX_OUTST);
  localparam int CNT_W = $clog2(MAX_OUTST) + 1;

  // Holding register toward the cache
  logic              hr_valid_reg;
  logic              hr_we_reg;
  logic [ADDR_W-1:0] hr_addr_reg;
  logic [DATA_W-1:0] hr_wdata_reg;

  // Arbitration and bookkeeping state
  logic [ID_W-1:0]  rr_ptr_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [ID_W-1:0]  owner_mem [MAX_OUTST];

  // Response path registers
  logic [NUM_CORES-1:0] rsp_valid_reg;
  logic [DATA_W-1:0]    rsp_rdata_reg;
  logic                 err_reg;

  // Combinational helpers
  logic                 grant_found;
  logic [ID_W-1:0]      grant_idx;
  logic [ID_W:0]        scan_idx;
  logic                 hr_free;
  logic                 capture;
  logic                 rsp_pop;
  logic                 rsp_unsolicited;
  logic [ID_W-1:0]      owner_head;
  logic [NUM_CORES-1:0] rsp_valid_next;
  logic [ID_W-1:0]      rr_ptr_next;

  // Round-robin search: first valid core at or after rr_ptr, wrapping
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      scan_idx = {1'b0, rr_ptr_reg} + (ID_W+1)'(k);
      if (scan_idx >= (ID_W+1)'(NUM_CORES))
        scan_idx = scan_idx - (ID_W+1)'(NUM_CORES);
      if (!grant_found && core_req_valid[scan_idx[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx[ID_W-1:0];
      end
    end
  end

  // HR can take a new request when empty or draining this cycle. Capture is
  // held off during reset so core_req_ready reads 0 while rst is low.
  assign hr_free         = !hr_valid_reg || cache_req_ready;
  assign capture         = rst && hr_free && (cnt_reg < CNT_W'(MAX_OUTST)) && grant_found;
  assign rsp_pop         = cache_rsp_valid && (cnt_reg != '0);
  assign rsp_unsolicited = cache_rsp_valid && (cnt_reg == '0);
  assign owner_head      = owner_mem[rd_ptr_reg];
  assign rr_ptr_next     = (grant_idx == ID_W'(NUM_CORES - 1)) ? '0 : grant_idx + ID_W'(1);

  // Per-core ready and response strobes decoded from the grant / FIFO head
  generate
    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core
      assign core_req_ready[gi] = capture && (grant_idx == ID_W'(gi));
      assign rsp_valid_next[gi] = rsp_pop && (owner_head == ID_W'(gi));
    end
  endgenerate

  // Holding register: refill on capture, otherwise empty once the cache accepts
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hr_valid_reg <= 1'b0;
      hr_we_reg    <= 1'b0;
      hr_addr_reg  <= '0;
      hr_wdata_reg <= '0;
    end else if (capture) begin
      hr_valid_reg <= 1'b1;
      hr_we_reg    <= core_req_we[grant_idx];
      hr_addr_reg  <= core_req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
      hr_wdata_reg <= core_req_wdata[int'(grant_idx)*DATA_W +: DATA_W];
    end else if (cache_req_ready) begin
      hr_valid_reg <= 1'b0;
    end
  end

  // Round-robin pointer, outstanding count and FIFO pointers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_reg <= '0;
      cnt_reg    <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (capture) begin
        rr_ptr_reg <= rr_ptr_next;
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (rsp_pop)
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      if (capture && !rsp_pop)
        cnt_reg <= cnt_reg + CNT_W'(1);
      else if (!capture && rsp_pop)
        cnt_reg <= cnt_reg - CNT_W'(1);
    end
  end

  // Owner FIFO storage; contents are meaningless outside the pointer window
  always_ff @(posedge clk) begin
    if (capture)
      owner_mem[wr_ptr_reg] <= grant_idx;
  end

  // Response routing and sticky unsolicited-response flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid_reg <= '0;
      rsp_rdata_reg <= '0;
      err_reg       <= 1'b0;
    end else begin
      rsp_valid_reg <= rsp_valid_next;
      if (rsp_pop)
        rsp_rdata_reg <= cache_rsp_rdata;
      if (rsp_unsolicited)
        err_reg <= 1'b1;
    end
  end

  assign cache_req_valid = hr_valid_reg;
  assign cache_req_we    = hr_we_reg;
  assign cache_req_addr  = hr_addr_reg;
  assign cache_req_wdata = hr_wdata_reg;
  assign core_rsp_valid  = rsp_valid_reg;
  assign core_rsp_rdata  = rsp_rdata_reg;
  assign err_unsolicited = err_reg;

endmodule
